// File: rtl/ptp_serializer_pkg.sv
// Shared types and constants for the ptp_serializer narrowing output stage.
package ptp_pkg;

    typedef enum logic {IDLE, SHIFT} ptp_state_t;

    // Mode bits restored on reset: MSB-first, one-shot.
    localparam logic MSB_FIRST_RST = 1'b1;
    localparam logic WRAP_RST      = 1'b0;

    function automatic int ptp_nchunk(int total, int w);
        return total / w;
    endfunction

endpackage

// File: rtl/ptp_serializer_if.sv
// Frame load / chunk output bundle between the serializer and its I/O wrapper.
interface ptp_serializer_if #(
    parameter int TOTAL     = 64,
    parameter int OUT_WIDTH = 8
);
    logic [TOTAL-1:0]     data_i;
    logic                 load_i;
    logic                 msb_first_i;
    logic                 wrap_i;
    logic                 step_i;
    logic [OUT_WIDTH-1:0] value_o;
    logic                 valid_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output data_i, load_i, msb_first_i, wrap_i, step_i,
        input  value_o, valid_o, busy_o, done_o
    );

    modport slave (
        input  data_i, load_i, msb_first_i, wrap_i, step_i,
        output value_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/ptp_serializer_rise_detect.sv
// Registered 0->1 edge detector; a level held high yields a single rise.
module rise_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/ptp_serializer.sv
// Snapshots a CHANNELS-word frame on load and emits it OUT_WIDTH bits per step rise.
module ptp_serializer
    import ptp_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int CH_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    ptp_serializer_if.slave bus
);
    localparam int TOTAL  = CHANNELS * CH_WIDTH;
    localparam int NCHUNK = ptp_nchunk(TOTAL, OUT_WIDTH);
    localparam int PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [PW-1:0] LAST = PW'(NCHUNK - 1);

    if ((TOTAL % OUT_WIDTH) != 0) begin : g_width_check
        $error("ptp_serializer: CHANNELS*CH_WIDTH must be a multiple of OUT_WIDTH");
    end

    ptp_state_t           state_q;
    logic [TOTAL-1:0]     snap_q;
    logic [PW-1:0]        ptr_q;
    logic                 msb_first_q;
    logic                 wrap_q;
    logic [OUT_WIDTH-1:0] value_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 step_rise;
    logic [PW-1:0]        chunk_idx;
    logic [OW-1:0]        chunk_off;
    logic [OUT_WIDTH-1:0] chunk;

    rise_detect u_step_rise (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (bus.step_i),
        .rise_o  (step_rise)
    );

    // MSB-first walks the chunk index downward from the top of the frame.
    always_comb begin
        chunk_idx = msb_first_q ? (LAST - ptr_q) : ptr_q;
        chunk_off = OW'(int'(chunk_idx) * OUT_WIDTH);
        chunk     = snap_q[chunk_off +: OUT_WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            ptr_q       <= '0;
            msb_first_q <= MSB_FIRST_RST;
            wrap_q      <= WRAP_RST;
            value_q     <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            // Load has priority over a coincident step, which is dropped.
            if (bus.load_i) begin
                state_q     <= SHIFT;
                snap_q      <= bus.data_i;
                ptr_q       <= '0;
                msb_first_q <= bus.msb_first_i;
                wrap_q      <= bus.wrap_i;
            end else if (state_q == SHIFT && step_rise) begin
                value_q <= chunk;
                valid_q <= 1'b1;
                if (ptr_q != LAST) begin
                    ptr_q <= ptr_q + 1'b1;
                end else if (wrap_q) begin
                    ptr_q <= '0;
                end else begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.value_o = value_q;
    assign bus.valid_o = valid_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = (state_q == SHIFT);
endmodule

// File: tb/tb_ptp_serializer.sv
// Directed bench: default 2x32->8 instance plus a 3x8->4 instance on the same clock.
module tb_ptp_serializer;
    logic clk;
    logic reset;
    int   nAsserts;
    int   nFail;

    ptp_serializer_if #(.TOTAL(64), .OUT_WIDTH(8)) busA ();
    ptp_serializer_if #(.TOTAL(24), .OUT_WIDTH(4)) busB ();

    ptp_serializer #(.CHANNELS(2), .CH_WIDTH(32), .OUT_WIDTH(8)) dutA (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (busA.slave)
    );

    ptp_serializer #(.CHANNELS(3), .CH_WIDTH(8), .OUT_WIDTH(4)) dutB (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic loadA(input logic [63:0] data, input logic msb, input logic wrap);
        busA.data_i      = data;
        busA.msb_first_i = msb;
        busA.wrap_i      = wrap;
        busA.load_i      = 1'b1;
        tick();
        busA.load_i      = 1'b0;
        busA.data_i      = 64'hDEAD_BEEF_0BAD_F00D;
        busA.msb_first_i = ~msb;
        busA.wrap_i      = ~wrap;
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] expValue,
                                 input logic expDone, input logic expBusy);
        busA.step_i = 1'b1;
        tick();
        checkOutput({tag, ".value"}, 64'(busA.value_o), 64'(expValue));
        checkOutput({tag, ".valid"}, 64'(busA.valid_o), 64'd1);
        checkOutput({tag, ".done"},  64'(busA.done_o),  64'(expDone));
        busA.step_i = 1'b0;
        tick();
        checkOutput({tag, ".validLow"}, 64'(busA.valid_o), 64'd0);
        checkOutput({tag, ".busy"},     64'(busA.busy_o),  64'(expBusy));
    endtask

    task automatic stepB(input string tag, input logic [3:0] expValue, input logic expDone);
        busB.step_i = 1'b1;
        tick();
        checkOutput({tag, ".value"}, 64'(busB.value_o), 64'(expValue));
        checkOutput({tag, ".valid"}, 64'(busB.valid_o), 64'd1);
        checkOutput({tag, ".done"},  64'(busB.done_o),  64'(expDone));
        busB.step_i = 1'b0;
        tick();
    endtask

    logic [7:0] expMsb [8];
    logic [7:0] expLsb [8];
    logic [3:0] expB   [6];
    logic [63:0] frame;

    initial begin
        nAsserts = 0;
        nFail    = 0;
        frame    = {32'h12345678, 32'h9ABCDEF0};
        expMsb   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        expLsb   = '{8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
        expB     = '{4'hA, 4'h1, 4'hB, 4'h2, 4'hC, 4'h3};
        busA.data_i = '0; busA.load_i = 0; busA.msb_first_i = 1; busA.wrap_i = 0; busA.step_i = 0;
        busB.data_i = '0; busB.load_i = 0; busB.msb_first_i = 1; busB.wrap_i = 0; busB.step_i = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst.value", 64'(busA.value_o), 64'd0);
        checkOutput("rst.valid", 64'(busA.valid_o), 64'd0);
        checkOutput("rst.busy",  64'(busA.busy_o),  64'd0);
        checkOutput("rst.done",  64'(busA.done_o),  64'd0);

        // Steps while idle are ignored.
        busA.step_i = 1'b1;
        tick();
        checkOutput("idle.valid", 64'(busA.valid_o), 64'd0);
        busA.step_i = 1'b0;
        tick();

        $display("[TB] MSB-first one-shot");
        loadA(frame, 1'b1, 1'b0);
        checkOutput("load.busy",  64'(busA.busy_o),  64'd1);
        checkOutput("load.valid", 64'(busA.valid_o), 64'd0);
        checkOutput("load.value", 64'(busA.value_o), 64'd0);
        for (int k = 0; k < 8; k++)
            applyStimulus($sformatf("msb%0d", k), expMsb[k], k == 7, k != 7);
        busA.step_i = 1'b1;
        tick();
        checkOutput("msb9.valid", 64'(busA.valid_o), 64'd0);
        checkOutput("msb9.value", 64'(busA.value_o), 64'hF0);
        busA.step_i = 1'b0;
        tick();

        $display("[TB] LSB-first one-shot");
        loadA(frame, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            applyStimulus($sformatf("lsb%0d", k), expLsb[k], k == 7, k != 7);

        $display("[TB] MSB-first wrap");
        loadA(frame, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++)
            applyStimulus($sformatf("wrap%0d", k), expMsb[k % 8], 1'b0, 1'b1);

        $display("[TB] held step and load/step collision");
        loadA(frame, 1'b1, 1'b0);
        busA.step_i = 1'b1;
        tick();
        checkOutput("held.value", 64'(busA.value_o), 64'h12);
        checkOutput("held.valid0", 64'(busA.valid_o), 64'd1);
        for (int c = 1; c < 5; c++) begin
            tick();
            checkOutput($sformatf("held.valid%0d", c), 64'(busA.valid_o), 64'd0);
        end
        busA.step_i = 1'b0;
        tick();
        busA.data_i = frame; busA.msb_first_i = 1'b1; busA.wrap_i = 1'b0;
        busA.load_i = 1'b1;
        busA.step_i = 1'b1;
        tick();
        busA.load_i = 1'b0;
        checkOutput("coll.valid", 64'(busA.valid_o), 64'd0);
        checkOutput("coll.busy",  64'(busA.busy_o),  64'd1);
        tick();
        checkOutput("coll.heldValid", 64'(busA.valid_o), 64'd0);
        busA.step_i = 1'b0;
        tick();
        applyStimulus("coll.first", 8'h12, 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        loadA(frame, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus($sformatf("pre%0d", k), expMsb[k], 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid.value", 64'(busA.value_o), 64'd0);
        checkOutput("mid.valid", 64'(busA.valid_o), 64'd0);
        checkOutput("mid.busy",  64'(busA.busy_o),  64'd0);
        checkOutput("mid.done",  64'(busA.done_o),  64'd0);
        loadA(frame, 1'b1, 1'b0);
        applyStimulus("post", 8'h12, 1'b0, 1'b1);

        $display("[TB] 3x8 -> 4 instance");
        busB.data_i = 24'hA1B2C3; busB.msb_first_i = 1'b1; busB.wrap_i = 1'b0;
        busB.load_i = 1'b1;
        tick();
        busB.load_i = 1'b0;
        busB.data_i = 24'h000000;
        checkOutput("b.busy", 64'(busB.busy_o), 64'd1);
        for (int k = 0; k < 6; k++)
            stepB($sformatf("b%0d", k), expB[k], k == 5);
        checkOutput("b.idle", 64'(busB.busy_o), 64'd0);
        busB.data_i = 24'hA1B2C3;
        busB.load_i = 1'b1;
        tick();
        busB.load_i = 1'b0;
        stepB("bm0", 4'hA, 1'b0);
        stepB("bm1", 4'h1, 1'b0);
        busB.load_i = 1'b1;
        tick();
        busB.load_i = 1'b0;
        checkOutput("bm.loadValid", 64'(busB.valid_o), 64'd0);
        checkOutput("bm.loadValue", 64'(busB.value_o), 64'h1);
        stepB("bm.restart", 4'hA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
